// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM sequencing arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RESP
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes plus the RAM-side bus of the arbiter, grouped as one interface.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wr;
    logic              mem_cs;
    logic [DATA_W-1:0] mem_dout;

    // The arbiter is the slave of the requesters and the sole master of the RAM pins.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output ack0, ack1, rdata, mem_addr, mem_din, mem_wr, mem_cs
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  ack0, ack1, rdata, mem_addr, mem_din, mem_wr, mem_cs
    );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// 2-way one-hot grant picker; round-robin by default, fixed priority to
// requester 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // last_grant is the index of the requester served most recently.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                grant = 2'b01;
`else
                grant = last_grant ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester sequencer for a single-port async-read RAM: SETUP, STROBE, RESP.
// RAM_ARB_FIXED_PRIO_EN selects fixed priority and drops the last-grant register.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic [1:0]        grant_q;
    logic              last_grant;
    logic              load;
    logic              capture;
    logic              cmd_we;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_cs_c;
    logic              mem_wr_c;
    logic              ack0_c;
    logic              ack1_c;

    assign req_vec = {bus.req1, bus.req0};

    rr_arb2 u_arb (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes and acks decode straight from state, so a reset edge drops them at once.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        mem_cs_c   = 1'b0;
        mem_wr_c   = 1'b0;
        ack0_c     = 1'b0;
        ack1_c     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                mem_cs_c   = 1'b1;
                state_next = STROBE;
            end
            STROBE: begin
                mem_cs_c   = 1'b1;
                mem_wr_c   = cmd_we;
                capture    = ~cmd_we;
                state_next = RESP;
            end
            RESP: begin
                ack0_c     = grant_q[0];
                ack1_c     = grant_q[1];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The command registers double as the RAM address/data pins, so those only move on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= 2'b00;
            cmd_we     <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rdata_q    <= '0;
        end else begin
            if (load) begin
                grant_q    <= grant;
                cmd_we     <= grant[1] ? bus.we1    : bus.we0;
                mem_addr_q <= grant[1] ? bus.addr1  : bus.addr0;
                mem_din_q  <= grant[1] ? bus.wdata1 : bus.wdata0;
            end
            if (capture) begin
                rdata_q <= bus.mem_dout;
            end
        end
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (load) begin
            last_grant <= grant[1];
        end
    end
`endif

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_cs   = mem_cs_c;
    assign bus.mem_wr   = mem_wr_c;
    assign bus.ack0     = ack0_c;
    assign bus.ack1     = ack1_c;
    assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024x8 RAM behind the mem_* pins.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    typedef struct {
        logic       port;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   both_ack_cycles;
    vec_t vecs[$];
    logic [7:0] ram [0:1023];

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async-read RAM; the write strobe is modelled as taking effect at the edge closing its cycle.
    assign bus.mem_dout = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_wr) ram[bus.mem_addr] <= bus.mem_din;
    end

    always @(negedge clk) begin
        if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both_ack_cycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input logic port, input logic we, input logic [9:0] addr, input logic [7:0] wdata);
        if (port) begin
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
        end else begin
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
        end
    endtask

    task automatic dropReq(input logic port);
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One transaction: latency to ack, single-cycle strobe, address/data on the bus, rdata at ack.
    task automatic applyStimulus(input vec_t v, input int idx);
        int         cycles;
        int         wr_cycles;
        logic       seen;
        logic [9:0] cs_addr;
        logic [7:0] wr_din;
        logic [7:0] rdata_at_ack;
        cycles = 0; wr_cycles = 0; seen = 1'b0;
        cs_addr = '0; wr_din = '0; rdata_at_ack = '0;
        @(posedge clk);
        #1 driveReq(v.port, v.we, v.addr, v.wdata);
        while (!seen && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.mem_cs === 1'b1) cs_addr = bus.mem_addr;
            if (bus.mem_wr === 1'b1) begin
                wr_cycles++;
                wr_din = bus.mem_din;
            end
            if ((v.port ? bus.ack1 : bus.ack0) === 1'b1) begin
                seen = 1'b1;
                rdata_at_ack = bus.rdata;
            end
        end
        checkOutput($sformatf("vec%0d_latency", idx), cycles, 3);
        checkOutput($sformatf("vec%0d_rdata", idx), {24'd0, rdata_at_ack}, {24'd0, v.exp_rdata});
        checkOutput($sformatf("vec%0d_wr_cycles", idx), wr_cycles, v.we ? 1 : 0);
        checkOutput($sformatf("vec%0d_mem_addr", idx), {22'd0, cs_addr}, {22'd0, v.addr});
        if (v.we) checkOutput($sformatf("vec%0d_mem_din", idx), {24'd0, wr_din}, {24'd0, v.wdata});
        @(posedge clk);
        #1 dropReq(v.port);
    endtask

    initial begin
        int   t0;
        int   t1;
        int   cycles;
        int   n_acks;
        int   stray;
        logic drop0;
        logic drop1;
        logic [7:0] rd0;
        logic [7:0] rd1;
        int   seq[8];

        compared = 0; mismatched = 0; both_ack_cycles = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

        vecs.push_back('{1'b0, 1'b1, 10'd5, 8'd10, 8'd0});
        vecs.push_back('{1'b0, 1'b0, 10'd5, 8'd0, 8'd10});
        for (int k = 0; k <= 16; k++) vecs.push_back('{1'b1, 1'b1, 10'(k), 8'(2 * k), 8'd10});
        for (int k = 0; k <= 16; k++) vecs.push_back('{1'b1, 1'b0, 10'(k), 8'd0, 8'(2 * k)});
        vecs.push_back('{1'b1, 1'b1, 10'd1023, 8'hA5, 8'd32});
        vecs.push_back('{1'b0, 1'b0, 10'd1023, 8'd0, 8'hA5});

        $display("[TB] reset values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack0", {31'd0, bus.ack0}, 0);
        checkOutput("rst_ack1", {31'd0, bus.ack1}, 0);
        checkOutput("rst_mem_wr", {31'd0, bus.mem_wr}, 0);
        checkOutput("rst_mem_cs", {31'd0, bus.mem_cs}, 0);
        checkOutput("rst_mem_addr", {22'd0, bus.mem_addr}, 0);
        checkOutput("rst_mem_din", {24'd0, bus.mem_din}, 0);
        checkOutput("rst_rdata", {24'd0, bus.rdata}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] vector table: single write/read, sweep, top address");
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        $display("[TB] contention after reset");
        doReset();
        @(posedge clk);
        #1 driveReq(1'b0, 1'b0, 10'd5, 8'd0);
        driveReq(1'b1, 1'b0, 10'd1023, 8'd0);
        t0 = 0; t1 = 0; cycles = 0; drop0 = 1'b0; drop1 = 1'b0; rd0 = '0; rd1 = '0;
        while (!(drop0 && drop1) && cycles < 20) begin
            @(posedge clk);
            cycles++;
            #1;
            if (t0 != 0 && !drop0) begin dropReq(1'b0); drop0 = 1'b1; end
            if (t1 != 0 && !drop1) begin dropReq(1'b1); drop1 = 1'b1; end
            @(negedge clk);
            if (bus.ack0 === 1'b1 && t0 == 0) begin t0 = cycles; rd0 = bus.rdata; end
            if (bus.ack1 === 1'b1 && t1 == 0) begin t1 = cycles; rd1 = bus.rdata; end
        end
        dropReq(1'b0); dropReq(1'b1);
        checkOutput("contend_ack0_time", t0, 3);
        checkOutput("contend_ack1_time", t1, 7);
        checkOutput("contend_rdata0", {24'd0, rd0}, 32'd10);
        checkOutput("contend_rdata1", {24'd0, rd1}, 32'hA5);

        $display("[TB] fairness with both requesters held");
        doReset();
        @(posedge clk);
        #1 driveReq(1'b0, 1'b0, 10'd5, 8'd0);
        driveReq(1'b1, 1'b0, 10'd1023, 8'd0);
        n_acks = 0; cycles = 0;
        while (n_acks < 8 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (bus.ack0 === 1'b1 && n_acks < 8) begin seq[n_acks] = 0; n_acks++; end
            if (bus.ack1 === 1'b1 && n_acks < 8) begin seq[n_acks] = 1; n_acks++; end
        end
        @(posedge clk);
        #1 dropReq(1'b0); dropReq(1'b1);
        checkOutput("fair_ack_count", n_acks, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < n_acks) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                checkOutput($sformatf("fair_grant%0d", i), seq[i], 0);
`else
                checkOutput($sformatf("fair_grant%0d", i), seq[i], i % 2);
`endif
            end
        end

        $display("[TB] reset during write strobe");
        @(posedge clk);
        #1 driveReq(1'b0, 1'b1, 10'd7, 8'h33);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_strobe_seen", {31'd0, bus.mem_wr}, 1);
        rst = 1'b1;
        dropReq(1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_mem_wr", {31'd0, bus.mem_wr}, 0);
        checkOutput("abort_mem_cs", {31'd0, bus.mem_cs}, 0);
        checkOutput("abort_ack0", {31'd0, bus.ack0}, 0);
        checkOutput("abort_mem_addr", {22'd0, bus.mem_addr}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) stray++;
        end
        checkOutput("abort_no_ack", stray, 0);
        applyStimulus('{1'b0, 1'b0, 10'd5, 8'd0, 8'd10}, 100);

        $display("[TB] back-to-back on requester 0");
        @(posedge clk);
        #1 driveReq(1'b0, 1'b0, 10'd1023, 8'd0);
        t0 = 0; t1 = 0; cycles = 0; rd0 = '0; rd1 = '0;
        while (t1 == 0 && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.ack0 === 1'b1) begin
                if (t0 == 0) begin t0 = cycles; rd0 = bus.rdata; end
                else begin t1 = cycles; rd1 = bus.rdata; end
            end
        end
        @(posedge clk);
        #1 dropReq(1'b0);
        checkOutput("b2b_ack_first", t0, 3);
        checkOutput("b2b_ack_second", t1, 7);
        checkOutput("b2b_rdata_first", {24'd0, rd0}, 32'hA5);
        checkOutput("b2b_rdata_second", {24'd0, rd1}, 32'hA5);

        repeat (3) @(posedge clk);
        checkOutput("acks_never_together", both_ack_cycles, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
